// File: rtl/msrh_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// msrh_fetch_ctrl_if
//   Bundles the fetch controller's bus signals: icache request/response,
//   redirect input and the decode-side instruction stream.
//   master : fetch controller side (drives o_*, samples i_*)
//   slave  : environment side (icache, branch/commit, decode)
// Parameters
//   VADDR_W      virtual address width
//   FETCH_BYTES  bytes per fetch block
// -----------------------------------------------------------------------------
interface msrh_fetch_ctrl_if #(
  parameter int VADDR_W     = 39,
  parameter int FETCH_BYTES = 16
);
  logic                     o_ic_req_valid;
  logic [VADDR_W-1:0]       o_ic_req_vaddr;
  logic                     i_ic_req_ready;
  logic                     i_ic_resp_valid;
  logic                     i_ic_resp_miss;
  logic [FETCH_BYTES*8-1:0] i_ic_resp_data;
  logic                     i_ic_refill_done;
  logic                     i_redirect_valid;
  logic [VADDR_W-1:0]       i_redirect_vaddr;
  logic                     o_inst_valid;
  logic [VADDR_W-1:0]       o_inst_pc;
  logic [FETCH_BYTES*8-1:0] o_inst_data;
  logic [FETCH_BYTES-1:0]   o_inst_be;
  logic                     i_inst_ready;

  modport master (
    output o_ic_req_valid, o_ic_req_vaddr,
    input  i_ic_req_ready, i_ic_resp_valid, i_ic_resp_miss, i_ic_resp_data,
    input  i_ic_refill_done, i_redirect_valid, i_redirect_vaddr,
    output o_inst_valid, o_inst_pc, o_inst_data, o_inst_be,
    input  i_inst_ready
  );

  modport slave (
    input  o_ic_req_valid, o_ic_req_vaddr,
    output i_ic_req_ready, i_ic_resp_valid, i_ic_resp_miss, i_ic_resp_data,
    output i_ic_refill_done, i_redirect_valid, i_redirect_vaddr,
    input  o_inst_valid, o_inst_pc, o_inst_data, o_inst_be,
    output i_inst_ready
  );
endinterface

// File: rtl/msrh_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// msrh_fetch_ctrl
//   Fetch controller between PC generation, icache and decode. Owns the fetch
//   PC, issues FETCH_BYTES-aligned requests, tracks the fixed two-stage icache
//   pipeline (s1, s2), replays from the missing PC on an icache miss and kills
//   everything in flight on a redirect. Hits are buffered in a credit-protected
//   circular fetch queue that feeds decode through valid/ready.
// Ports
//   i_clk      clock
//   i_reset_n  asynchronous reset, active low
//   bus        msrh_fetch_ctrl_if.master: icache req/resp, refill pulse,
//              redirect, decode instruction stream
// Configuration
//   MSRH_FETCH_BYPASS_EN  when defined, a valid s2 hit arriving while the queue
//                         is empty is presented on o_inst_* in the same cycle
//                         (latency accept+2); otherwise accept+3.
// -----------------------------------------------------------------------------
module msrh_fetch_ctrl #(
  parameter int                 VADDR_W     = 39,
  parameter int                 FETCH_BYTES = 16,
  parameter int                 FQ_DEPTH    = 4,
  parameter logic [VADDR_W-1:0] PC_INIT     = 'h8000_0000
) (
  input logic              i_clk,
  input logic              i_reset_n,
  msrh_fetch_ctrl_if.master bus
);

  localparam int OFF_W  = $clog2(FETCH_BYTES);
  localparam int IDX_W  = $clog2(FQ_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int SUM_W  = PTR_W + 1;
  localparam int DATA_W = FETCH_BYTES * 8;

  typedef enum logic {ST_FETCH, ST_MISS_WAIT} state_e;

  function automatic logic [VADDR_W-1:0] align_pc(input logic [VADDR_W-1:0] pc);
    align_pc = {pc[VADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // Bytes below the entry offset belong to the previous block (redirect into
  // the middle of a block).
  function automatic logic [FETCH_BYTES-1:0] byte_en(input logic [OFF_W-1:0] off);
    for (int i = 0; i < FETCH_BYTES; i++) begin
      byte_en[i] = (i >= int'(off));
    end
  endfunction

  state_e               state_q, state_d;
  logic [VADDR_W-1:0]   pc_q, pc_d;
  logic                 tag_vld_p1_q, tag_vld_p1_d;
  logic                 tag_vld_p2_q, tag_vld_p2_d;
  logic [VADDR_W-1:0]   tag_pc_p1_q, tag_pc_p2_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [VADDR_W-1:0]   fq_pc_q   [FQ_DEPTH];
  logic [DATA_W-1:0]    fq_data_q [FQ_DEPTH];

  logic                 redirect;
  logic                 s2_resp, s2_hit, s2_miss;
  logic [1:0]           inflight;
  logic [PTR_W-1:0]     fq_count;
  logic                 fq_empty, fq_full;
  logic                 credit_ok;
  logic                 req_valid, accept;
  logic                 head_vld, fq_push, fq_pop;
  logic                 inst_valid;
  logic [VADDR_W-1:0]   inst_pc;
  logic [DATA_W-1:0]    inst_data;

  assign redirect  = bus.i_redirect_valid;
  assign s2_resp   = tag_vld_p2_q & bus.i_ic_resp_valid;
  assign s2_hit    = s2_resp & ~bus.i_ic_resp_miss & ~redirect;
  assign s2_miss   = s2_resp &  bus.i_ic_resp_miss & ~redirect;
  assign inflight  = {1'b0, tag_vld_p1_q} + {1'b0, tag_vld_p2_q};
  assign fq_count  = wr_ptr_q - rd_ptr_q;
  assign fq_empty  = (wr_ptr_q == rd_ptr_q);
  assign fq_full   = (fq_count == PTR_W'(FQ_DEPTH));
  assign credit_ok = ({{(SUM_W-2){1'b0}}, inflight} + {1'b0, fq_count}) < SUM_W'(FQ_DEPTH);
  assign head_vld  = ~fq_empty;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_FETCH;
    else            state_q <= state_d;
  end

  // FSM: next state (redirect > s2 miss > refill_done)
  always_comb begin
    state_d = state_q;
    if (redirect)                                         state_d = ST_FETCH;
    else if (s2_miss)                                     state_d = ST_MISS_WAIT;
    else if (state_q == ST_MISS_WAIT && bus.i_ic_refill_done) state_d = ST_FETCH;
  end

  // FSM: outputs. A request in the miss cycle would be younger than the
  // missing block and discarded anyway, so it is held back too.
  always_comb begin
    req_valid = i_reset_n & (state_q == ST_FETCH) & credit_ok & ~redirect & ~s2_miss;
  end

  assign accept             = req_valid & bus.i_ic_req_ready;
  assign bus.o_ic_req_valid = req_valid;
  assign bus.o_ic_req_vaddr = align_pc(pc_q);

  // ---------------------------------------------------------------------------
  // s0: fetch PC and request tag into s1
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = bus.i_redirect_vaddr;
    else if (s2_miss) pc_d = tag_pc_p2_q;
    else if (accept)  pc_d = align_pc(pc_q) + VADDR_W'(FETCH_BYTES);
    tag_vld_p1_d = accept;
    tag_vld_p2_d = tag_vld_p1_q & ~redirect & ~s2_miss;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q         <= PC_INIT;
      tag_vld_p1_q <= 1'b0;
      tag_vld_p2_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      tag_vld_p1_q <= tag_vld_p1_d;
      tag_vld_p2_q <= tag_vld_p2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // s1 -> s2: tag PCs (qualified by the valid bits above)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    tag_pc_p1_q <= pc_q;
    tag_pc_p2_q <= tag_pc_p1_q;
  end

  // ---------------------------------------------------------------------------
  // s2: fetch queue write / decode read
  // ---------------------------------------------------------------------------
`ifdef MSRH_FETCH_BYPASS_EN
  logic byp_vld;
  assign byp_vld    = fq_empty & s2_hit;
  assign inst_valid = head_vld | byp_vld;
  // A bypassed block consumed in the same cycle never enters the queue.
  assign fq_push    = s2_hit & ~(byp_vld & bus.i_inst_ready);
  assign inst_pc    = head_vld ? fq_pc_q[rd_ptr_q[IDX_W-1:0]]   : tag_pc_p2_q;
  assign inst_data  = head_vld ? fq_data_q[rd_ptr_q[IDX_W-1:0]] : bus.i_ic_resp_data;
`else
  assign inst_valid = head_vld;
  assign fq_push    = s2_hit;
  assign inst_pc    = fq_pc_q[rd_ptr_q[IDX_W-1:0]];
  assign inst_data  = fq_data_q[rd_ptr_q[IDX_W-1:0]];
`endif

  assign fq_pop = head_vld & bus.i_inst_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(fq_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(fq_pop);
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fq_push) begin
      fq_pc_q[wr_ptr_q[IDX_W-1:0]]   <= tag_pc_p2_q;
      fq_data_q[wr_ptr_q[IDX_W-1:0]] <= bus.i_ic_resp_data;
    end
  end

  // Credits reserve a slot for every in-flight request.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_reset_n) !(fq_push && fq_full));

  assign bus.o_inst_valid = inst_valid;
  assign bus.o_inst_pc    = inst_valid ? inst_pc   : '0;
  assign bus.o_inst_data  = inst_valid ? inst_data : '0;
  assign bus.o_inst_be    = inst_valid ? byte_en(inst_pc[OFF_W-1:0]) : '0;

endmodule

// File: tb/tb_msrh_fetch_ctrl.sv
module tb_msrh_fetch_ctrl;
  localparam int          VA   = 39;
  localparam int          FB   = 16;
  localparam int          NCYC = 4000;
  localparam logic [38:0] PC0  = 39'h80000000;
`ifdef MSRH_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { logic [38:0] pc; int due; bit live; } ic_t;
  typedef struct { logic [38:0] pc; logic [127:0] data; } fq_t;

  logic i_clk = 1'b0;
  logic i_reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;

  msrh_fetch_ctrl_if #(.VADDR_W(VA), .FETCH_BYTES(FB)) bus ();

  msrh_fetch_ctrl #(.VADDR_W(VA), .FETCH_BYTES(FB), .FQ_DEPTH(4), .PC_INIT(PC0)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [38:0] align16(input logic [38:0] a);
    return a & ~39'hF;
  endfunction

  ic_t         ic_q[$];
  fq_t         mq[$];
  logic [38:0] model_pc;
  bit          model_wait;
  int          refill_cnt;
  int          delivered;
  int          rdy_mode;

  initial begin
    ic_t         cur;
    fq_t         exp_e;
    bit          have_cur, redir, miss, refill, s2_live, miss_now, hit_now, byp;
    bit          exp_req, exp_vld, acc;
    int          live_n, sel;
    logic [38:0] tgt, pc_pre;
    logic [127:0] rdata;
    logic [15:0] exp_be;

    i_reset_n                = 1'b0;
    bus.i_ic_req_ready       = 1'b0;
    bus.i_ic_resp_valid      = 1'b0;
    bus.i_ic_resp_miss       = 1'b0;
    bus.i_ic_resp_data       = '0;
    bus.i_ic_refill_done     = 1'b0;
    bus.i_redirect_valid     = 1'b0;
    bus.i_redirect_vaddr     = '0;
    bus.i_inst_ready         = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_eq("rst_req_valid",  128'(bus.o_ic_req_valid), 128'(0));
    check_eq("rst_req_vaddr",  128'(bus.o_ic_req_vaddr), 128'(PC0));
    check_eq("rst_inst_valid", 128'(bus.o_inst_valid),   128'(0));
    check_eq("rst_inst_pc",    128'(bus.o_inst_pc),      128'(0));
    check_eq("rst_inst_be",    128'(bus.o_inst_be),      128'(0));
    @(negedge i_clk);
    i_reset_n  = 1'b1;
    model_pc   = PC0;
    model_wait = 1'b0;
    refill_cnt = 0;
    delivered  = 0;
    rdy_mode   = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge i_clk);
      // icache response for whatever was accepted two cycles ago
      have_cur = 1'b0;
      if (ic_q.size() > 0 && ic_q[0].due == cyc) begin
        cur      = ic_q.pop_front();
        have_cur = 1'b1;
      end
      rdata = {$urandom, $urandom, $urandom, $urandom};
      miss  = ($urandom_range(0, 4) == 0);
      bus.i_ic_resp_valid = have_cur || ($urandom_range(0, 9) == 0);
      bus.i_ic_resp_miss  = bus.i_ic_resp_valid && miss;
      bus.i_ic_resp_data  = rdata;
      // refill: timed after a miss, plus stray pulses that must be ignored in FETCH
      if (model_wait && refill_cnt > 0) refill_cnt--;
      refill = (model_wait && refill_cnt == 0) || ($urandom_range(0, 29) == 0);
      bus.i_ic_refill_done = refill;
      // redirects: directed wrap and mid-block targets, plus random ones
      sel   = $urandom_range(0, 2);
      tgt   = (sel == 0) ? 39'h7F_FFFF_FFF0 :
              (sel == 1) ? 39'h80001006 : ({7'($urandom), $urandom} & ~39'h1);
      redir = (cyc == 300) || (cyc == 1500) || ($urandom_range(0, 39) == 0);
      if (cyc == 300)  tgt = 39'h7F_FFFF_FFF0;
      if (cyc == 1500) tgt = 39'h80001006;
      bus.i_redirect_valid = redir;
      bus.i_redirect_vaddr = tgt;
      bus.i_ic_req_ready   = ($urandom_range(0, 4) != 0);
      if (cyc % 64 == 0) rdy_mode = $urandom_range(0, 2);
      bus.i_inst_ready = (rdy_mode == 0) ? ($urandom_range(0, 6) != 0) :
                         (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
      #1;

      s2_live  = have_cur && cur.live;
      miss_now = s2_live && miss && !redir;
      hit_now  = s2_live && !miss && !redir;
      live_n   = int'(s2_live);
      foreach (ic_q[i]) if (ic_q[i].live) live_n++;
      exp_req = !model_wait && (live_n + mq.size() < 4) && !redir && !miss_now;
      check_eq("req_valid", 128'(bus.o_ic_req_valid), 128'(exp_req));
      if (exp_req) check_eq("req_vaddr", 128'(bus.o_ic_req_vaddr), 128'(align16(model_pc)));

      byp     = BYP && mq.size() == 0 && hit_now;
      exp_vld = (mq.size() > 0) || byp;
      check_eq("inst_valid", 128'(bus.o_inst_valid), 128'(exp_vld));
      if (exp_vld) begin
        if (mq.size() > 0) exp_e = mq[0];
        else begin
          exp_e.pc   = cur.pc;
          exp_e.data = rdata;
        end
        exp_be = 16'hFFFF << exp_e.pc[3:0];
        check_eq("inst_pc",   128'(bus.o_inst_pc),   128'(exp_e.pc));
        check_eq("inst_data", bus.o_inst_data,       exp_e.data);
        check_eq("inst_be",   128'(bus.o_inst_be),   128'(exp_be));
        if (bus.i_inst_ready) delivered++;
      end

      // model update for the coming edge
      acc    = bus.o_ic_req_valid && bus.i_ic_req_ready;
      pc_pre = model_pc;
      if (exp_vld && bus.i_inst_ready && mq.size() > 0) void'(mq.pop_front());
      if (redir) begin
        foreach (ic_q[i]) ic_q[i].live = 1'b0;
        mq.delete();
        model_pc   = tgt;
        model_wait = 1'b0;
      end else if (miss_now) begin
        foreach (ic_q[i]) ic_q[i].live = 1'b0;
        model_pc   = cur.pc;
        model_wait = 1'b1;
        refill_cnt = $urandom_range(1, 6);
      end else begin
        if (hit_now && !(byp && bus.i_inst_ready)) begin
          exp_e.pc   = cur.pc;
          exp_e.data = rdata;
          mq.push_back(exp_e);
        end
        if (model_wait && refill) model_wait = 1'b0;
        if (acc) model_pc = align16(model_pc) + 39'd16;
      end
      if (acc) ic_q.push_back('{pc: pc_pre, due: cyc + 2, live: !redir && !miss_now});
    end

    check_eq("progress", 128'(delivered > 200), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
